// File: rtl/constraint_sample_scheduler.sv
// Drives LFSR candidates into an external constraint checker and streams out the ones that pass
// every constraint. Define REJECT_STATS_EN to add the fail_mask / rej_count rejection statistics.
module constraint_sample_scheduler #(
  parameter int unsigned VEC_W     = 64,
  parameter int unsigned NCON      = 35,
  parameter int unsigned CHK_LAT   = 1,
  parameter int unsigned MAX_TRIES = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [63:0]       seed,
  output logic [VEC_W-1:0]  cand,
  input  logic [NCON-1:0]   chk_ok,
  output logic [VEC_W-1:0]  samp_data,
  output logic              samp_valid,
  input  logic              samp_ready,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
`ifdef REJECT_STATS_EN
  output logic [31:0]       tries_total,
  output logic [NCON-1:0]   fail_mask,
  output logic [31:0]       rej_count
`else
  output logic [31:0]       tries_total
`endif
);

  localparam int unsigned WcntW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  // Galois taps for x^64 + x^63 + x^61 + x^60 + 1, right-shifting form
  localparam logic [63:0] Taps = 64'hD800_0000_0000_0000;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StGen  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StEmit = 3'd3;
  localparam logic [2:0] StFin  = 3'd4;
  localparam logic [2:0] StErr  = 3'd5;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? Taps : 64'h0);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [63:0]      lfsr_q, lfsr_d, lfsr_nxt;
  logic [VEC_W-1:0] cand_q, cand_d;
  logic [VEC_W-1:0] samp_data_q, samp_data_d;
  logic             samp_valid_q, samp_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      tries_total_q, tries_total_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [CNT_W-1:0] tries_q, tries_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
`ifdef REJECT_STATS_EN
  logic [NCON-1:0]  fail_mask_q, fail_mask_d;
  logic [31:0]      rej_q, rej_d;
`endif

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    lfsr_nxt      = lfsr_step(lfsr_q);
    cand_d        = cand_q;
    samp_data_d   = samp_data_q;
    samp_valid_d  = samp_valid_q;
    done_d        = 1'b0;
    err_d         = err_q;
    tries_total_d = tries_total_q;
    left_d        = left_q;
    tries_d       = tries_q;
    wcnt_d        = wcnt_q;
`ifdef REJECT_STATS_EN
    fail_mask_d   = fail_mask_q;
    rej_d         = rej_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (num_samples == '0) begin
            done_d = 1'b1;
          end else begin
            lfsr_d        = (seed == 64'h0) ? 64'h1 : seed;
            left_d        = num_samples;
            tries_d       = '0;
            tries_total_d = '0;
`ifdef REJECT_STATS_EN
            fail_mask_d   = '0;
            rej_d         = '0;
`endif
            state_d       = StGen;
          end
        end
      end
      StGen: begin
        lfsr_d  = lfsr_nxt;
        cand_d  = lfsr_nxt[VEC_W-1:0];
        wcnt_d  = WcntW'(CHK_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          if (tries_total_q != '1) tries_total_d = tries_total_q + 32'd1;
          if (&chk_ok) begin
            samp_data_d  = cand_q;
            samp_valid_d = 1'b1;
            state_d      = StEmit;
          end else begin
            tries_d = tries_q + 1'b1;
`ifdef REJECT_STATS_EN
            fail_mask_d = fail_mask_q | ~chk_ok;
            if (rej_q != '1) rej_d = rej_q + 32'd1;
`endif
            if (tries_q == CNT_W'(MAX_TRIES - 1)) begin
              // done and err_timeout rise together on the way into StErr
              done_d  = 1'b1;
              err_d   = 1'b1;
              state_d = StErr;
            end else begin
              state_d = StGen;
            end
          end
        end
      end
      StEmit: begin
        if (samp_ready) begin
          samp_valid_d = 1'b0;
          tries_d      = '0;
          left_d       = left_q - 1'b1;
          if (left_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            state_d = StGen;
          end
        end
      end
      StFin: state_d = StIdle;
      StErr: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      lfsr_q        <= 64'h1;
      cand_q        <= '0;
      samp_data_q   <= '0;
      samp_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      tries_total_q <= '0;
      left_q        <= '0;
      tries_q       <= '0;
      wcnt_q        <= '0;
`ifdef REJECT_STATS_EN
      fail_mask_q   <= '0;
      rej_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      cand_q        <= cand_d;
      samp_data_q   <= samp_data_d;
      samp_valid_q  <= samp_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
      tries_total_q <= tries_total_d;
      left_q        <= left_d;
      tries_q       <= tries_d;
      wcnt_q        <= wcnt_d;
`ifdef REJECT_STATS_EN
      fail_mask_q   <= fail_mask_d;
      rej_q         <= rej_d;
`endif
    end
  end

  assign cand        = cand_q;
  assign samp_data   = samp_data_q;
  assign samp_valid  = samp_valid_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign tries_total = tries_total_q;
`ifdef REJECT_STATS_EN
  assign fail_mask   = fail_mask_q;
  assign rej_count   = rej_q;
`endif

endmodule

// File: tb/tb_constraint_sample_scheduler.sv
// Randomized bench for constraint_sample_scheduler against a sequence-level reference model.
module tb_constraint_sample_scheduler;
  localparam int unsigned VEC_W     = 48;
  localparam int unsigned NCON      = 35;
  localparam int unsigned CHK_LAT   = 2;
  localparam int unsigned MAX_TRIES = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int          Budget    = 3000;

  logic             clk = 1'b0;
  logic             rst, start, samp_ready;
  logic [CNT_W-1:0] num_samples;
  logic [63:0]      seed;
  logic [VEC_W-1:0] cand, samp_data, cand_d1;
  logic [NCON-1:0]  chk_ok;
  logic             samp_valid, busy, done, err_timeout;
  logic [31:0]      tries_total;
`ifdef REJECT_STATS_EN
  logic [NCON-1:0]  fail_mask;
  logic [31:0]      rej_count;
`endif
  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;

  constraint_sample_scheduler #(
    .VEC_W(VEC_W), .NCON(NCON), .CHK_LAT(CHK_LAT), .MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .seed(seed),
    .cand(cand), .chk_ok(chk_ok), .samp_data(samp_data), .samp_valid(samp_valid),
    .samp_ready(samp_ready), .busy(busy), .done(done), .err_timeout(err_timeout),
`ifdef REJECT_STATS_EN
    .tries_total(tries_total), .fail_mask(fail_mask), .rej_count(rej_count)
`else
    .tries_total(tries_total)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] step(input logic [63:0] s);
    logic [63:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 64'hD800000000000000;
    return t;
  endfunction

  // 0: all pass, 1: bit 7 stuck low, 2: two data-dependent constraints
  function automatic logic [NCON-1:0] chk_fn(input int md, input logic [VEC_W-1:0] c);
    logic [NCON-1:0] ok;
    ok = '1;
    if (md == 1) ok[7] = 1'b0;
    else if (md == 2) begin
      ok[0]  = c[0];
      ok[20] = c[5] | c[9];
    end
    return ok;
  endfunction

  // one register stage gives the checker a two-cycle latency
  always_ff @(posedge clk) cand_d1 <= cand;
  assign chk_ok = chk_fn(mode, cand_d1);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_cand"}, 64'(cand), 64'h0);
    check_eq({tag, "_sdata"}, 64'(samp_data), 64'h0);
    check_eq({tag, "_svalid"}, 64'(samp_valid), 64'h0);
    check_eq({tag, "_busy"}, 64'(busy), 64'h0);
    check_eq({tag, "_done"}, 64'(done), 64'h0);
    check_eq({tag, "_err"}, 64'(err_timeout), 64'h0);
    check_eq({tag, "_tries"}, 64'(tries_total), 64'h0);
`ifdef REJECT_STATS_EN
    check_eq({tag, "_mask"}, 64'(fail_mask), 64'h0);
    check_eq({tag, "_rej"}, 64'(rej_count), 64'h0);
`endif
  endtask

  task automatic run(input logic [63:0] sd, input int n, input int md, input bit stall,
                     input bit poke);
    logic [63:0]      s;
    logic [VEC_W-1:0] c, exp_first, hold_data, hold_cand;
    logic [31:0]      exp_tot;
    bit               exp_err, pend, finished, rdy;
    int               got, tries, stall_left;
    logic [VEC_W-1:0] exp_q[$];
`ifdef REJECT_STATS_EN
    logic [NCON-1:0]  exp_mask;
    logic [31:0]      exp_rej;
    exp_mask = '0;
    exp_rej  = '0;
`endif
    // reference: walk the candidate sequence, ignoring cycle timing
    s = (sd == 64'h0) ? 64'h1 : sd;
    exp_first = step(s)  [VEC_W-1:0];
    exp_tot = 0; exp_err = 0; got = 0; tries = 0;
    while (got < n) begin
      s = step(s);
      c = s[VEC_W-1:0];
      if (exp_tot != 32'hFFFFFFFF) exp_tot++;
      if (&chk_fn(md, c)) begin
        exp_q.push_back(c);
        got++;
        tries = 0;
      end else begin
`ifdef REJECT_STATS_EN
        exp_mask = exp_mask | ~chk_fn(md, c);
        exp_rej++;
`endif
        tries++;
        if (tries == MAX_TRIES) begin
          exp_err = 1;
          break;
        end
      end
    end

    mode = md;
    @(negedge clk);
    start = 1'b1; num_samples = CNT_W'(n); seed = sd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pend = 0; finished = 0; stall_left = stall ? 5 : 0;
    for (int cyc = 0; cyc < Budget && !finished; cyc++) begin
      if (cyc == 0) check_eq("busy_after_start", 64'(busy), 64'h1);
      if (cyc == 1) check_eq("first_cand", 64'(cand), 64'(exp_first));
      if (poke) begin
        start = (cyc == 3);
        num_samples = 16'd9;
        seed = 64'h1234;
      end
      if (done) begin
        finished = 1;
      end else begin
        if (samp_valid) begin
          if (pend) begin
            check_eq("stall_data", 64'(samp_data), 64'(hold_data));
            check_eq("stall_cand", 64'(cand), 64'(hold_cand));
          end
          rdy = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
          if (stall_left > 0) stall_left--;
          samp_ready = rdy;
          if (rdy) begin
            if (exp_q.size() == 0) check_eq("extra_sample", 64'h1, 64'h0);
            else check_eq("sample", 64'(samp_data), 64'(exp_q.pop_front()));
            pend = 0;
          end else begin
            pend = 1;
            hold_data = samp_data;
            hold_cand = cand;
          end
        end else begin
          samp_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!finished) check_eq("done_timeout", 64'h0, 64'h1);
    check_eq("missing_samples", 64'(exp_q.size()), 64'h0);
    check_eq("tries_total", 64'(tries_total), 64'(exp_tot));
    check_eq("err_timeout", 64'(err_timeout), 64'(exp_err));
`ifdef REJECT_STATS_EN
    check_eq("fail_mask", 64'(fail_mask), 64'(exp_mask));
    check_eq("rej_count", 64'(rej_count), 64'(exp_rej));
`endif
    @(posedge clk);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'h0);
    check_eq("idle_after_done", 64'(busy), 64'h0);
  endtask

  task automatic zero_start();
    @(negedge clk);
    start = 1'b1; num_samples = '0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_done", 64'(done), 64'h1);
    check_eq("zero_busy", 64'(busy), 64'h0);
    check_eq("zero_err_clr", 64'(err_timeout), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check_eq("zero_done_pulse", 64'(done), 64'h0);
    check_eq("zero_busy2", 64'(busy), 64'h0);
  endtask

  task automatic reset_mid(input bit in_emit);
    bit seen;
    mode = 0;
    samp_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; num_samples = 16'd3; seed = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (in_emit) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (samp_valid) seen = 1;
        else begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      check_eq("emit_reached", 64'(seen), 64'h1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_zero(in_emit ? "rst_emit" : "rst_wait");
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_no_done", 64'(done), 64'h0);
    check_eq("rst_idle", 64'(busy), 64'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; seed = '0; samp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    run(64'h0, 3, 0, 0, 0);
    run(64'h1, 3, 0, 0, 0);
    run({$urandom, $urandom}, 2, 0, 1, 0);
    run({$urandom, $urandom}, 1, 1, 0, 0);
    zero_start();
    run({$urandom, $urandom}, 4, 2, 0, 1);
    reset_mid(1'b0);
    reset_mid(1'b1);
    run({$urandom, $urandom}, 3, 2, 0, 0);
    for (int i = 0; i < 16; i++) begin
      run({$urandom, $urandom}, int'($urandom_range(1, 6)), (i % 3 == 0) ? 0 : 2,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
